// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and bridge state type for the generic-bus AHB master.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ERR
  } bridge_state_t;

endpackage

// File: rtl/gen_bus_size_decode.sv
// Maps a lane-aligned byte_en pattern to AHB HSIZE plus the low address offset.
module gen_bus_size_decode
  import ahb_pkg::*;
(
  input  logic [3:0] byte_en,
  output hsize_t     hsize,
  output logic [1:0] offset,
  output logic       illegal
);

  always_comb begin
    hsize   = HSIZE_WORD;
    offset  = 2'd0;
    illegal = 1'b0;
    case (byte_en)
      4'b1111: begin hsize = HSIZE_WORD; offset = 2'd0; end
      4'b0011: begin hsize = HSIZE_HALF; offset = 2'd0; end
      4'b1100: begin hsize = HSIZE_HALF; offset = 2'd2; end
      4'b0001: begin hsize = HSIZE_BYTE; offset = 2'd0; end
      4'b0010: begin hsize = HSIZE_BYTE; offset = 2'd1; end
      4'b0100: begin hsize = HSIZE_BYTE; offset = 2'd2; end
      4'b1000: begin hsize = HSIZE_BYTE; offset = 2'd3; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/generic_bus_ahb_master.sv
// Generic-bus to AHB-Lite master bridge: one outstanding, non-pipelined SINGLE transfer.
module generic_bus_ahb_master
  import ahb_pkg::*;
#(
  parameter logic [3:0]  HPROT_VAL      = 4'b0011,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ren,
  input  logic        wen,
  input  logic [3:0]  byte_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        error,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
  localparam logic        TO_EN  = (TIMEOUT_CYCLES != 0);

  bridge_state_t state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          write_q, write_d;
  hsize_t        size_q, size_d;
  logic          illegal_q, illegal_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          done_ok, done_err;

  hsize_t        dec_size;
  logic [1:0]    dec_off;
  logic          dec_illegal;

  gen_bus_size_decode u_size_decode (
    .byte_en (byte_en),
    .hsize   (dec_size),
    .offset  (dec_off),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    size_d    = size_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    done_ok   = 1'b0;
    done_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ren || wen) begin
          addr_d    = {addr[31:2], dec_off};
          wdata_d   = wdata;
          write_d   = wen;
          size_d    = dec_size;
          illegal_d = (ren && wen) || dec_illegal;
          state_d   = illegal_d ? ST_ERR : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        // A protocol-violating single-cycle ERROR (HREADY high) is still reported as a failure.
        if (HREADY) begin
          done_ok  = (HRESP == HRESP_OKAY);
          done_err = (HRESP == HRESP_ERROR);
          state_d  = ST_IDLE;
        end else if (HRESP == HRESP_ERROR) begin
          state_d = ST_ERR;
        end else if (TO_EN && (cnt_q >= TO_LIM)) begin
          done_err = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_ERR: begin
        // Locally rejected requests never reached the bus, so they need not wait for HREADY.
        if (illegal_q || HREADY) begin
          done_err = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      size_q    <= HSIZE_WORD;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      size_q    <= size_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy   = !(done_ok || done_err);
  assign error  = done_err;
  assign rdata  = (done_ok && !write_q) ? HRDATA : '0;
  assign HTRANS = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = addr_q;
  assign HSIZE  = size_q;
  assign HWRITE = write_q;
  assign HWDATA = wdata_q;
  assign HBURST = HBURST_SINGLE;
  assign HPROT  = HPROT_VAL;

endmodule

// File: tb/tb_generic_bus_ahb_master.sv
// Directed bench for generic_bus_ahb_master: default instance plus a TIMEOUT_CYCLES=4 instance.
module tb_generic_bus_ahb_master;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ren, wen;
  logic [3:0]  byte_en;
  logic [31:0] addr, wdata, HRDATA;
  logic        HREADY, HRESP;

  logic        busy, error, HWRITE;
  logic [31:0] rdata, HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  logic        to_busy, to_error, to_HWRITE;
  logic [31:0] to_rdata, to_HADDR, to_HWDATA;
  logic [1:0]  to_HTRANS;
  logic [2:0]  to_HSIZE, to_HBURST;
  logic [3:0]  to_HPROT;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  generic_bus_ahb_master dut (
    .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .byte_en(byte_en), .addr(addr),
    .wdata(wdata), .busy(busy), .rdata(rdata), .error(error), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  generic_bus_ahb_master #(.TIMEOUT_CYCLES(4)) dut_to (
    .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .byte_en(byte_en), .addr(addr),
    .wdata(wdata), .busy(to_busy), .rdata(to_rdata), .error(to_error), .HADDR(to_HADDR),
    .HTRANS(to_HTRANS), .HWRITE(to_HWRITE), .HSIZE(to_HSIZE), .HBURST(to_HBURST),
    .HPROT(to_HPROT), .HWDATA(to_HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0; ren = 1'b0; wen = 1'b0; byte_en = 4'h0; addr = '0; wdata = '0;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy",   32'(busy),   32'd1);
    chk("rst_error",  32'(error),  32'd0);
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr",  HADDR,       32'd0);
    chk("rst_hwdata", HWDATA,      32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hsize",  32'(HSIZE),  32'd2);
    chk("rst_rdata",  rdata,       32'd0);
    chk("rst_hburst", 32'(HBURST), 32'd0);
    chk("rst_hprot",  32'(HPROT),  32'h3);
    @(posedge CLK); #1 nRST = 1'b1;

    // Word read, zero wait states
    @(posedge CLK); #1;
    ren = 1'b1; addr = 32'h8000_0004; byte_en = 4'hF; HRDATA = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk("rd_c0_busy",   32'(busy),   32'd1);
    chk("rd_c0_htrans", 32'(HTRANS), 32'd0);
    @(posedge CLK); @(negedge CLK);
    chk("rd_c1_htrans", 32'(HTRANS), 32'h2);
    chk("rd_c1_haddr",  HADDR,       32'h8000_0004);
    chk("rd_c1_hsize",  32'(HSIZE),  32'd2);
    chk("rd_c1_hwrite", 32'(HWRITE), 32'd0);
    chk("rd_c1_busy",   32'(busy),   32'd1);
    @(posedge CLK); @(negedge CLK);
    chk("rd_c2_busy",   32'(busy),   32'd0);
    chk("rd_c2_error",  32'(error),  32'd0);
    chk("rd_c2_rdata",  rdata,       32'hDEAD_BEEF);
    chk("rd_c2_htrans", 32'(HTRANS), 32'd0);
    @(posedge CLK); #1 ren = 1'b0;
    @(negedge CLK);
    chk("rd_idle_busy", 32'(busy), 32'd1);

    // Byte write, lane 2, three wait states
    @(posedge CLK); #1;
    wen = 1'b1; addr = 32'h10; byte_en = 4'b0100; wdata = 32'h00AB_0000; HREADY = 1'b1;
    @(posedge CLK); @(negedge CLK);
    chk("wr_c1_htrans", 32'(HTRANS), 32'h2);
    chk("wr_c1_haddr",  HADDR,       32'h12);
    chk("wr_c1_hsize",  32'(HSIZE),  32'd0);
    chk("wr_c1_hwrite", 32'(HWRITE), 32'd1);
    @(posedge CLK); #1 HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("wr_wait_busy",   32'(busy),   32'd1);
      chk("wr_wait_hwdata", HWDATA,      32'h00AB_0000);
      chk("wr_wait_htrans", 32'(HTRANS), 32'd0);
      @(posedge CLK);
    end
    #1 HREADY = 1'b1;
    @(negedge CLK);
    chk("wr_c5_busy",   32'(busy),  32'd0);
    chk("wr_c5_error",  32'(error), 32'd0);
    chk("wr_c5_hwdata", HWDATA,     32'h00AB_0000);
    @(posedge CLK); #1 wen = 1'b0;

    // Two-cycle ERROR response, then a clean back-to-back read
    ren = 1'b1; addr = 32'h20; byte_en = 4'hF;
    @(posedge CLK); @(negedge CLK);
    chk("er_c1_htrans", 32'(HTRANS), 32'h2);
    @(posedge CLK); #1; HREADY = 1'b0; HRESP = 1'b1;
    @(negedge CLK);
    chk("er_c2_busy", 32'(busy), 32'd1);
    @(posedge CLK); #1 HREADY = 1'b1;
    @(negedge CLK);
    chk("er_c3_busy",  32'(busy),  32'd0);
    chk("er_c3_error", 32'(error), 32'd1);
    chk("er_c3_rdata", rdata,      32'd0);
    @(posedge CLK); #1;
    HRESP = 1'b0; addr = 32'h40; byte_en = 4'b1100; HRDATA = 32'h1234_5678;
    @(posedge CLK); @(negedge CLK);
    chk("b2b_c1_haddr", HADDR,      32'h42);
    chk("b2b_c1_hsize", 32'(HSIZE), 32'd1);
    @(posedge CLK); @(negedge CLK);
    chk("b2b_c2_busy",  32'(busy),  32'd0);
    chk("b2b_c2_error", 32'(error), 32'd0);
    chk("b2b_c2_rdata", rdata,      32'h1234_5678);
    @(posedge CLK); #1 ren = 1'b0;

    // Illegal byte_en, with HREADY low to show no bus involvement
    ren = 1'b1; byte_en = 4'b0110; HREADY = 1'b0;
    @(negedge CLK);
    chk("ill_c0_busy", 32'(busy), 32'd1);
    @(posedge CLK); @(negedge CLK);
    chk("ill_c1_htrans", 32'(HTRANS), 32'd0);
    chk("ill_c1_busy",   32'(busy),   32'd0);
    chk("ill_c1_error",  32'(error),  32'd1);
    chk("ill_c1_rdata",  rdata,       32'd0);
    @(posedge CLK); #1;
    HREADY = 1'b1; wen = 1'b1; byte_en = 4'hF;
    @(posedge CLK); @(negedge CLK);
    chk("rw_c1_htrans", 32'(HTRANS), 32'd0);
    chk("rw_c1_busy",   32'(busy),   32'd0);
    chk("rw_c1_error",  32'(error),  32'd1);
    @(posedge CLK); #1; ren = 1'b0; wen = 1'b0;
    @(negedge CLK);
    chk("rw_idle_busy",  32'(busy),  32'd1);
    chk("rw_idle_error", 32'(error), 32'd0);

    // Timeout (dut_to) and reset while stalled in DATA (dut)
    @(posedge CLK); #1;
    ren = 1'b1; addr = 32'h8000_0004; byte_en = 4'hF; HREADY = 1'b1;
    @(posedge CLK); @(negedge CLK);
    chk("to_c1_htrans", 32'(to_HTRANS), 32'h2);
    @(posedge CLK); #1 HREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("to_wait_busy", 32'(to_busy), 32'd1);
      @(posedge CLK);
    end
    @(negedge CLK);
    chk("to_c6_busy",   32'(to_busy),  32'd0);
    chk("to_c6_error",  32'(to_error), 32'd1);
    chk("to_c6_rdata",  to_rdata,      32'd0);
    chk("noto_c6_busy", 32'(busy),     32'd1);
    @(posedge CLK); #1 ren = 1'b0;
    @(negedge CLK);
    chk("noto_c7_busy",  32'(busy),    32'd1);
    chk("noto_c7_haddr", HADDR,        32'h8000_0004);
    chk("to_c7_busy",    32'(to_busy), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("arst_busy",   32'(busy),   32'd1);
    chk("arst_htrans", 32'(HTRANS), 32'd0);
    chk("arst_haddr",  HADDR,       32'd0);
    chk("arst_hsize",  32'(HSIZE),  32'd2);
    HREADY = 1'b1;
    @(posedge CLK); #1;
    nRST = 1'b1; ren = 1'b1; addr = 32'h8; byte_en = 4'b0001; HRDATA = 32'hCAFE_F00D;
    @(posedge CLK); @(negedge CLK);
    chk("post_c1_htrans", 32'(HTRANS), 32'h2);
    chk("post_c1_haddr",  HADDR,       32'h8);
    chk("post_c1_hsize",  32'(HSIZE),  32'd0);
    @(posedge CLK); @(negedge CLK);
    chk("post_c2_busy",  32'(busy), 32'd0);
    chk("post_c2_rdata", rdata,     32'hCAFE_F00D);
    @(posedge CLK); #1 ren = 1'b0;
    repeat (2) @(posedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
